dds_wave_control: RTL and testbench
===================================

DDS_WAVE_CONTROL -- requirements
Module: dds_wave_control

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 500: clk cycles per output sample (100 kHz at 50 MHz); legal when SAMPLE_DIV >= ROM_LAT+2.
REQ-002 SHALL have parameter ROM_LAT, default 2: clocks from a rom_addr register update to the edge on which rom_q is sampled.
REQ-003 SHALL have parameter FSTEP, default 32'h0001_0000: tuning-word increment per freq_up/freq_down pulse.
REQ-004 SHALL have parameter FMAX, default 32'h4000_0000: maximum tuning word.
REQ-005 SHALL have parameter FWORD_RST, default 32'h0010_0000: tuning word after reset.
REQ-006 clk  in  1  system clock, 50 MHz; all logic on rising edge.
REQ-007 rst_n  in  1  synchronous reset, active-low.
REQ-008 en  in  1  when high, sample ticks run.
REQ-009 freq_up, freq_down  in  1 each  one-clk command pulses.
REQ-010 amp_up, amp_down  in  1 each  one-clk command pulses.
REQ-011 wave_next  in  1  one-clk pulse; advance waveform.
REQ-012 rom_addr  out  11  registered sine-ROM address.
REQ-013 rom_q  in  8  sine-ROM data, offset binary (128 = zero).
REQ-014 dac_value  out  8  registered sample to the DAC driver, offset binary.
REQ-015 dac_valid  out  1  one-clk pulse when dac_value updates.
REQ-016 freq_word  out  32  current tuning word, for display.
REQ-017 wave_sel  out  2  current waveform: 0 sine, 1 square, 2 triangle, 3 saw.
REQ-018 amp  out  4  current amplitude code, 0..15.

Function
REQ-019 Tick counter SHALL count 0..SAMPLE_DIV-1 while en=1; tick is asserted in the clk where the count equals SAMPLE_DIV-1, then the count wraps to 0; while en=0 the counter holds and no tick occurs.
REQ-020 On tick, phase (32 bit) SHALL load phase+freq_word modulo 2^32, and rom_addr SHALL load bits [31:21] of the new phase in the same clk.
REQ-021 On tick, wave_sel and amp SHALL be latched into the pipeline with the new phase; later changes do not affect a sample already in flight.
REQ-022 With p = bits [31:24] of the latched phase, raw sample SHALL be: sine = rom_q; square = p[7] ? 255 : 0; saw = p; triangle = p[7] ? ~{p[6:0],0} : {p[6:0],0}.
REQ-023 Scaling SHALL be dac = 128 + (((raw-128) * (amp+1)) >>> 4), using signed arithmetic of at least 13 bits; the result always lies in 0..255.
REQ-024 dac_value SHALL update, and dac_valid SHALL pulse for exactly one clk, ROM_LAT+1 clocks after the tick clk, for all waveforms (equal latency).
REQ-025 freq_up SHALL add FSTEP to freq_word, saturating at FMAX; freq_down SHALL subtract FSTEP, saturating at 0.
REQ-026 freq_up and freq_down asserted in the same clk SHALL leave freq_word unchanged.
REQ-027 amp_up and amp_down SHALL step amp by 1, saturating at 15 and 0; both asserted in the same clk SHALL leave amp unchanged.
REQ-028 wave_next SHALL advance wave_sel 0->1->2->3->0.
REQ-029 Command pulses SHALL be accepted in any clk, including tick clks, and SHALL take effect on the next clk edge.
REQ-030 When en falls, a sample already in the pipeline SHALL still complete; afterwards dac_value holds its last value.

Reset
REQ-031 With rst_n=0 at a clk edge, the block SHALL set: tick counter 0, phase 0, pipeline flushed (no dac_valid from pre-reset ticks), rom_addr 0, dac_value 128, dac_valid 0, freq_word FWORD_RST, wave_sel 0, amp 15.
REQ-032 The first tick after release SHALL occur SAMPLE_DIV clks after the first clk with rst_n=1 and en=1.

Verification
REQ-033 Reset: hold rst_n=0 for 1 clk mid-run -> next clk: dac_value=128, rom_addr=0, dac_valid=0, freq_word=FWORD_RST, wave_sel=0, amp=15; no stale dac_valid pulse.
REQ-034 Saw ramp: SAMPLE_DIV=8, ROM_LAT=2, freq_word=32'h0100_0000, wave_sel=3, amp=15 -> dac_value 1,2,3,... one per 8 clks, 255 followed by 0; each dac_valid 3 clks after its tick.
REQ-035 Scaling: saw with p=0 and amp=7 -> dac_value=64; p=255 and amp=0 -> 135; square with amp=15 -> 0 / 255.
REQ-036 Sine path: bench ROM model returns rom_q = rom_addr[7:0] after ROM_LAT clks -> dac_value equals the model data for the matching address; rom_addr steps by freq_word>>21 per tick.
REQ-037 Saturation: 0x4000 freq_up pulses from FWORD_RST -> freq_word=FMAX; freq_up and freq_down together -> unchanged; amp_down x20 -> amp=0, then square output is 120 / 135.
REQ-038 en gating: deassert en during a tick -> that sample completes with one dac_valid, then no further dac_valid and phase frozen; reassert en -> next tick SAMPLE_DIV clks later counting from the held count.

Source files
------------

// File: rtl/dds_wave_control.sv
// Direct digital synthesis control: sample-rate phase accumulator, waveform
// shaping (sine ROM / square / triangle / saw) and amplitude scaling toward a DAC.
module dds_wave_control #(
    parameter int          SAMPLE_DIV = 500,
    parameter int          ROM_LAT    = 2,
    parameter logic [31:0] FSTEP      = 32'h0001_0000,
    parameter logic [31:0] FMAX       = 32'h4000_0000,
    parameter logic [31:0] FWORD_RST  = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        freq_up,
    input  logic        freq_down,
    input  logic        amp_up,
    input  logic        amp_down,
    input  logic        wave_next,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_q,
    output logic [7:0]  dac_value,
    output logic        dac_valid,
    output logic [31:0] freq_word,
    output logic [1:0]  wave_sel,
    output logic [3:0]  amp
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam int LAST_STG = ROM_LAT - 1;

    typedef struct packed {
        logic [1:0] wave;
        logic [3:0] amp;
        logic [7:0] p;
    } meta_t;

    logic [CW-1:0]      cnt_r;
    logic               tick_s;
    logic [31:0]        phase_r;
    logic [31:0]        phase_nxt_s;
    logic [10:0]        rom_addr_r;
    logic [ROM_LAT-1:0] vld_r;
    meta_t              meta_r [ROM_LAT];
    logic [7:0]         sample_s;
    logic [7:0]         dac_value_r;
    logic               dac_valid_r;
    logic [31:0]        freq_word_r;
    logic [31:0]        freq_nxt_s;
    logic [1:0]         wave_sel_r;
    logic [1:0]         wave_nxt_s;
    logic [3:0]         amp_r;
    logic [3:0]         amp_nxt_s;

    function automatic logic [7:0] raw_sample(input logic [1:0] wave,
                                              input logic [7:0] p,
                                              input logic [7:0] rom_data);
        logic [7:0] r;
        case (wave)
            2'd0:    r = rom_data;
            2'd1:    r = p[7] ? 8'hFF : 8'h00;
            2'd2:    r = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            2'd3:    r = p;
            default: r = p;
        endcase
        return r;
    endfunction

    // Centre on 128, multiply by (amp+1)/16, re-bias; 13-bit signed never overflows.
    function automatic logic [7:0] scale_sample(input logic [7:0] raw,
                                                input logic [3:0] amp_code);
        logic signed [12:0] centered;
        logic signed [12:0] gain;
        logic signed [12:0] prod;
        logic signed [12:0] res;
        centered = $signed({5'b0_0000, raw}) - 13'sd128;
        gain     = $signed({9'b0_0000_0000, amp_code}) + 13'sd1;
        prod     = centered * gain;
        res      = (prod >>> 4) + 13'sd128;
        return res[7:0];
    endfunction

    assign tick_s      = en && (cnt_r == CNT_LAST);
    assign phase_nxt_s = phase_r + freq_word_r;
    assign sample_s    = scale_sample(raw_sample(meta_r[LAST_STG].wave,
                                                 meta_r[LAST_STG].p, rom_q),
                                      meta_r[LAST_STG].amp);

    // Sample-rate divider; holds its count while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= tick_s ? '0 : cnt_r + CW'(1);
        end
    end

    // Phase accumulator, ROM address and the in-flight sample pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r     <= 32'h0000_0000;
            rom_addr_r  <= 11'h000;
            vld_r       <= '0;
            dac_value_r <= 8'd128;
            dac_valid_r <= 1'b0;
            for (int i = 0; i < ROM_LAT; i++) begin
                meta_r[i] <= '0;
            end
        end else begin
            if (tick_s) begin
                phase_r    <= phase_nxt_s;
                rom_addr_r <= phase_nxt_s[31:21];
            end
            vld_r[0]  <= tick_s;
            meta_r[0] <= '{wave: wave_sel_r, amp: amp_r, p: phase_nxt_s[31:24]};
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_r[i]  <= vld_r[i-1];
                meta_r[i] <= meta_r[i-1];
            end
            // Final stage lines up with rom_q for the address issued on the tick.
            dac_valid_r <= vld_r[LAST_STG];
            if (vld_r[LAST_STG]) begin
                dac_value_r <= sample_s;
            end
        end
    end

    // User command decode with saturation; opposing pulses cancel.
    always_comb begin
        freq_nxt_s = freq_word_r;
        amp_nxt_s  = amp_r;
        wave_nxt_s = wave_sel_r;
        case ({freq_up, freq_down})
            2'b10: begin
                if (freq_word_r >= FMAX - FSTEP) freq_nxt_s = FMAX;
                else                             freq_nxt_s = freq_word_r + FSTEP;
            end
            2'b01: begin
                if (freq_word_r <= FSTEP) freq_nxt_s = 32'h0000_0000;
                else                      freq_nxt_s = freq_word_r - FSTEP;
            end
            default: freq_nxt_s = freq_word_r;
        endcase
        case ({amp_up, amp_down})
            2'b10: begin
                if (amp_r == 4'd15) amp_nxt_s = amp_r;
                else                amp_nxt_s = amp_r + 4'd1;
            end
            2'b01: begin
                if (amp_r == 4'd0) amp_nxt_s = amp_r;
                else               amp_nxt_s = amp_r - 4'd1;
            end
            default: amp_nxt_s = amp_r;
        endcase
        if (wave_next) wave_nxt_s = wave_sel_r + 2'd1;
        else           wave_nxt_s = wave_sel_r;
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            freq_word_r <= FWORD_RST;
            wave_sel_r  <= 2'd0;
            amp_r       <= 4'd15;
        end else begin
            freq_word_r <= freq_nxt_s;
            wave_sel_r  <= wave_nxt_s;
            amp_r       <= amp_nxt_s;
        end
    end

    assign rom_addr  = rom_addr_r;
    assign dac_value = dac_value_r;
    assign dac_valid = dac_valid_r;
    assign freq_word = freq_word_r;
    assign wave_sel  = wave_sel_r;
    assign amp       = amp_r;

endmodule

// File: tb/tb_dds_wave_control.sv
// Scoreboard bench for dds_wave_control: directed stimulus pushes hand-computed
// DAC samples; a negedge monitor pops one per dac_valid pulse.
module tb_dds_wave_control;

    localparam int SD = 8;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        freq_up = 1'b0, freq_down = 1'b0;
    logic        amp_up = 1'b0, amp_down = 1'b0;
    logic        wave_next = 1'b0;
    logic [10:0] rom_addr;
    logic [7:0]  rom_q = 8'd0;
    logic [7:0]  dac_value;
    logic        dac_valid;
    logic [31:0] freq_word;
    logic [1:0]  wave_sel;
    logic [3:0]  amp;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_samp = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    dds_wave_control #(.SAMPLE_DIV(SD), .ROM_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .freq_up(freq_up), .freq_down(freq_down),
        .amp_up(amp_up), .amp_down(amp_down), .wave_next(wave_next),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .dac_value(dac_value), .dac_valid(dac_valid),
        .freq_word(freq_word), .wave_sel(wave_sel), .amp(amp)
    );

    // ROM model: data = address low byte, sampled by the DUT ROM_LAT clks after the address.
    always @(posedge clk) rom_q <= rom_addr[7:0];

    // Monitor: every dac_valid pulse must match the next scoreboard entry.
    always @(negedge clk) begin : mon
        logic [7:0] exp_v;
        if (dac_valid === 1'b1) begin
            n_vec++;
            n_samp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_dac_valid: got value %0d, expected no pulse", dac_value);
            end else begin
                exp_v = exp_q.pop_front();
                if (dac_value !== exp_v) begin
                    n_err++;
                    $display("FAIL dac_sample_%0d: got %0d expected %0d", n_samp, dac_value, exp_v);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Mask order: freq_up, freq_down, amp_up, amp_down, wave_next.
    task automatic cmd(input logic [4:0] m, input int n);
        @(negedge clk);
        {freq_up, freq_down, amp_up, amp_down, wave_next} = m;
        repeat (n) @(negedge clk);
        {freq_up, freq_down, amp_up, amp_down, wave_next} = 5'b0_0000;
    endtask

    task automatic wait_addr(input string name);
        logic [10:0] prev;
        int k;
        prev = rom_addr;
        k = 0;
        while (rom_addr == prev && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (rom_addr == prev) begin
            n_err++;
            $display("FAIL %s: rom_addr stuck at 0x%0h, expected a tick within 40 clks", name, prev);
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 4000) begin
            @(posedge clk);
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d samples outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        // Power-on reset values
        repeat (3) @(negedge clk);
        check("rst_dac_value", 32'(dac_value), 32'd128);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_dac_valid", 32'(dac_valid), 32'd0);
        check("rst_freq_word", freq_word, 32'h0010_0000);
        check("rst_wave_sel", 32'(wave_sel), 32'd0);
        check("rst_amp", 32'(amp), 32'd15);
        rst_n = 1'b1;

        // Saw ramp at one LSB per sample, wraps 255 -> 0
        cmd(5'b1_0000, 240);
        check("freq_to_ramp", freq_word, 32'h0100_0000);
        cmd(5'b0_0001, 3);
        check("wave_saw", 32'(wave_sel), 32'd3);
        for (int i = 1; i <= 257; i++) exp_q.push_back(8'(i));
        @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7)  check("first_tick_not_early", 32'(rom_addr), 32'h000);
            if (k == 8)  check("first_tick_addr", 32'(rom_addr), 32'h008);
            if (k == 9)  check("latency_not_early", 32'(dac_valid), 32'd0);
            if (k == 10) check("latency_3clk", 32'(dac_valid), 32'd1);
        end
        wait_drain("saw_ramp_drain");

        // Mid-run reset with a sample in flight: no stale pulse
        en = 1'b1;
        wait_addr("tick_before_reset");
        rst_n = 1'b0;
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_dac_value", 32'(dac_value), 32'd128);
        check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_dac_valid", 32'(dac_valid), 32'd0);
        check("mid_rst_freq_word", freq_word, 32'h0010_0000);
        check("mid_rst_wave_sel", 32'(wave_sel), 32'd0);
        check("mid_rst_amp", 32'(amp), 32'd15);
        repeat (10) @(negedge clk);

        // Scaling: saw p=0, amp=7 -> 64
        cmd(5'b0_0001, 3);
        cmd(5'b0_0010, 8);
        check("amp_7", 32'(amp), 32'd7);
        repeat (3) exp_q.push_back(8'd64);
        en = 1'b1;
        wait_drain("scale_amp7_drain");
        cmd(5'b0_0010, 20);
        check("amp_sat_0", 32'(amp), 32'd0);

        // Frequency and amplitude saturation / cancellation
        cmd(5'b1_0000, 32'h4000);
        check("freq_sat_fmax", freq_word, 32'h4000_0000);
        cmd(5'b1_1000, 1);
        check("freq_both_hold", freq_word, 32'h4000_0000);
        cmd(5'b0_1000, 1);
        check("freq_down_one", freq_word, 32'h3FFF_0000);
        cmd(5'b1_0000, 1);
        check("freq_up_one", freq_word, 32'h4000_0000);
        cmd(5'b0_0110, 1);
        check("amp_both_hold", 32'(amp), 32'd0);
        cmd(5'b0_0100, 1);
        check("amp_up_one", 32'(amp), 32'd1);
        cmd(5'b0_0010, 1);
        check("amp_down_one", 32'(amp), 32'd0);

        // Square at amp 0 then amp 15; p steps 0x40, 0x80, 0xC0, 0x00
        cmd(5'b0_0001, 2);
        check("wave_square", 32'(wave_sel), 32'd1);
        exp_q.push_back(8'd120); exp_q.push_back(8'd135);
        exp_q.push_back(8'd135); exp_q.push_back(8'd120);
        en = 1'b1;
        wait_drain("square_amp0_drain");
        cmd(5'b0_0100, 16);
        check("amp_sat_15", 32'(amp), 32'd15);
        exp_q.push_back(8'd0);   exp_q.push_back(8'd255);
        exp_q.push_back(8'd255); exp_q.push_back(8'd0);
        en = 1'b1;
        wait_drain("square_amp15_drain");

        // Sine through the ROM model; address step 0x1FB per tick
        cmd(5'b0_1000, 160);
        check("freq_sine", freq_word, 32'h3F60_0000);
        cmd(5'b0_0001, 3);
        check("wave_sine", 32'(wave_sel), 32'd0);
        exp_q.push_back(8'd252); exp_q.push_back(8'd247); exp_q.push_back(8'd242);
        en = 1'b1;
        wait_addr("sine_tick");
        check("sine_addr_step", 32'(rom_addr), 32'h1FC);
        wait_drain("sine_drain");

        // en gating: drop en right after a tick; sample completes, phase freezes
        exp_q.push_back(8'd237);
        en = 1'b1;
        wait_addr("gate_tick");
        en = 1'b0;
        check("gate_addr", 32'(rom_addr), 32'h7ED);
        repeat (20) @(negedge clk);
        check("gate_frozen", 32'(rom_addr), 32'h7ED);
        check("gate_completed", 32'(exp_q.size()), 32'd0);
        en = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.push_back(8'd232);
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) check("resume_not_early", 32'(rom_addr), 32'h7ED);
            if (k == 5) check("resume_from_held", 32'(rom_addr), 32'h1E8);
        end
        wait_drain("resume_drain");
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
